// File: rtl/cache_port_arbiter_pkg.sv
// Shared CPU/cache port bundles and arbiter id type.
// Imported by the arbiter top and its in-order id FIFO.
package cache_definition;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic [19:0] addr;
    logic [31:0] data;
  } cpu_to_cache_type;

  typedef struct packed {
    logic        ready;
    logic        stopped;
    logic [31:0] data;
  } cache_to_cpu_type;

  // 0 = instruction fetch (req0), 1 = data (req1)
  typedef logic arb_id_t;

  localparam int ARB_MAX_OUTST = 4;

endpackage

// File: rtl/cache_port_arbiter_fifo.sv
// arb_id_fifo: in-order FIFO of requester ids for reads in flight.
// Ports: clk, rst, push/din, pop/dout, full, empty, count (registered).
module arb_id_fifo
  import cache_definition::*;
#(
  parameter  int DEPTH = ARB_MAX_OUTST,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  arb_id_t      din,
  output arb_id_t      dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  arb_id_t       mem_q [DEPTH];
  arb_id_t       mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wr, rd;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem_q[rp_q];

  always_comb begin
    wr    = push & ~full;
    rd    = pop & ~empty;
    mem_d = mem_q;
    if (wr) mem_d[wp_q] = din;
    // Pointers wrap naturally since DEPTH is a power of two
    wp_d  = wp_q + AW'(wr);
    rp_d  = rp_q + AW'(rd);
    cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin sharing of one cache CPU port between ifetch (req0) and data (req1).
// Ports: req0/req1 in, responses out, arb_to_cache/cache_to_arb, outstanding, err_orphan.
module cache_port_arbiter
  import cache_definition::*;
#(
  parameter  int MAX_OUTST = ARB_MAX_OUTST,
  localparam int CW        = $clog2(MAX_OUTST) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  cpu_to_cache_type req0_to_arb,
  output cache_to_cpu_type arb_to_req0,
  input  cpu_to_cache_type req1_to_arb,
  output cache_to_cpu_type arb_to_req1,
  output cpu_to_cache_type arb_to_cache,
  input  cache_to_cpu_type cache_to_arb,
  output logic [CW-1:0]    outstanding,
  output logic             err_orphan
);

  arb_id_t          prio_q, prio_d;
  logic             err_q, err_d;
  arb_id_t          grant;
  arb_id_t          head;
  cpu_to_cache_type sel;
  logic             both;
  logic             accept;
  logic             push, pop;
  logic             full, empty;

  arb_id_fifo #(.DEPTH(MAX_OUTST)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (grant),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (outstanding)
  );

  always_comb begin
    both  = req0_to_arb.valid & req1_to_arb.valid;
    grant = both ? prio_q : arb_id_t'(req1_to_arb.valid);
    sel   = grant ? req1_to_arb : req0_to_arb;
    arb_to_cache = sel;
    // Full blocks reads using the registered count only, so a pop
    // in the same cycle cannot open a ready-to-valid path.
    arb_to_cache.valid = sel.valid & ~(~sel.rw & full) & ~rst;
    accept = arb_to_cache.valid & ~cache_to_arb.stopped;
    push   = accept & ~sel.rw;
    pop    = cache_to_arb.ready & ~empty;
    prio_d = (accept & both) ? ~grant : prio_q;
    err_d  = err_q | (cache_to_arb.ready & empty);
  end

  always_comb begin
    arb_to_req0.data    = cache_to_arb.data;
    arb_to_req1.data    = cache_to_arb.data;
    arb_to_req0.ready   = pop & (head == 1'b0) & ~rst;
    arb_to_req1.ready   = pop & (head == 1'b1) & ~rst;
    arb_to_req0.stopped = rst | ~(accept & (grant == 1'b0));
    arb_to_req1.stopped = rst | ~(accept & (grant == 1'b1));
  end

  assign err_orphan = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      prio_q <= prio_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench for cache_port_arbiter: directed scenarios plus random mix.
// Reads push expected data per requester; a monitor checks every ready.
module tb_cache_port_arbiter;
  import cache_definition::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  cpu_to_cache_type r0, r1, ac;
  cache_to_cpu_type c, a0, a1;
  logic [2:0]       outst;
  logic             err;

  cache_port_arbiter #(.MAX_OUTST(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_to_arb  (r0),
    .arb_to_req0  (a0),
    .req1_to_arb  (r1),
    .arb_to_req1  (a1),
    .arb_to_cache (ac),
    .cache_to_arb (c),
    .outstanding  (outst),
    .err_orphan   (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [19:0] cache_q[$];

  int   mcount = 0;
  logic mprio  = 1'b0;
  logic merr   = 1'b0;
  bit   acc0, acc1;

  cpu_to_cache_type idle = '0;

  function automatic logic [31:0] fdat(input logic [19:0] a);
    return {a[11:0], a} ^ 32'hCAFE_0000;
  endfunction

  function automatic cpu_to_cache_type mk(input logic rw,
                                          input logic [19:0] a);
    cpu_to_cache_type t;
    t.valid = 1'b1;
    t.rw    = rw;
    t.addr  = a;
    t.data  = $urandom;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One clock: drive at posedge+1, check combinational outputs and
  // advance the reference model at the following negedge.
  task automatic cyc(input cpu_to_cache_type q0, input cpu_to_cache_type q1,
                     input logic cs, input logic cr);
    logic             g, ve, ae, rd;
    cpu_to_cache_type sel;
    @(posedge clk);
    #1;
    r0 = q0;
    r1 = q1;
    c.stopped = cs;
    c.ready   = cr;
    if (cr && cache_q.size() > 0) c.data = fdat(cache_q.pop_front());
    else c.data = $urandom;
    @(negedge clk);
    chk("outstanding", 32'(outst), 32'(mcount));
    chk("err_orphan", 32'(err), 32'(merr));
    g   = (q0.valid && q1.valid) ? mprio : q1.valid;
    sel = g ? q1 : q0;
    rd  = ~sel.rw;
    ve  = sel.valid && !(rd && mcount == 4);
    ae  = ve && !cs;
    chk("cache_valid", 32'(ac.valid), 32'(ve));
    if (ve) chk("cache_addr", 32'(ac.addr), 32'(sel.addr));
    chk("stopped0", 32'(a0.stopped), 32'(!(ae && !g)));
    chk("stopped1", 32'(a1.stopped), 32'(!(ae && g)));
    acc0 = ae && !g;
    acc1 = ae && g;
    if (ae && rd) begin
      if (g) exp_q1.push_back(fdat(sel.addr));
      else   exp_q0.push_back(fdat(sel.addr));
      cache_q.push_back(ac.addr);
    end
    if (ae && q0.valid && q1.valid) mprio = ~g;
    if (cr && mcount == 0) merr = 1'b1;
    mcount = mcount + int'(ae && rd) - int'(cr && mcount > 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (a0.ready) begin
        chk("ready0_expected", 32'(exp_q0.size() > 0), 32'd1);
        if (exp_q0.size() > 0) chk("data0", a0.data, exp_q0.pop_front());
      end
      if (a1.ready) begin
        chk("ready1_expected", 32'(exp_q1.size() > 0), 32'd1);
        if (exp_q1.size() > 0) chk("data1", a1.data, exp_q1.pop_front());
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 12; i++)
      cyc(idle, idle, 1'b0, cache_q.size() > 0);
  endtask

  cpu_to_cache_type p0, p1;

  initial begin
    r0 = '0;
    r1 = '0;
    c  = '0;
    #3;
    chk("rst_outst", 32'(outst), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready0", 32'(a0.ready), 32'd0);
    chk("rst_ready1", 32'(a1.ready), 32'd0);
    chk("rst_stop0", 32'(a0.stopped), 32'd1);
    chk("rst_stop1", 32'(a1.stopped), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // single read from req0, then its response
    cyc(mk(1'b0, 20'h00010), idle, 1'b0, 1'b0);
    chk("s1_stop0", 32'(a0.stopped), 32'd0);
    cyc(idle, idle, 1'b0, 1'b1);
    chk("s1_ready0", 32'(a0.ready), 32'd1);
    chk("s1_ready1", 32'(a1.ready), 32'd0);

    // both requesters read back-to-back: alternating grants
    p0 = mk(1'b0, 20'h01000);
    p1 = mk(1'b0, 20'h02000);
    for (int i = 0; i < 4; i++) begin
      cyc(p0, p1, 1'b0, 1'b0);
      chk("s2_grant1", 32'(!a1.stopped), 32'(i % 2));
      if (acc0) p0 = mk(1'b0, 20'h01000 + 20'(i));
      if (acc1) p1 = mk(1'b0, 20'h02000 + 20'(i));
    end
    drain();

    // fill the id FIFO, then check blocking and write bypass
    for (int i = 0; i < 4; i++)
      cyc(mk(1'b0, 20'h03000 + 20'(i)), idle, 1'b0, 1'b0);
    p0 = mk(1'b0, 20'h03100);
    cyc(p0, idle, 1'b0, 1'b0);
    chk("s3_stop5", 32'(a0.stopped), 32'd1);
    chk("s3_outst", 32'(outst), 32'd4);
    cyc(idle, mk(1'b1, 20'h00020), 1'b0, 1'b0);
    chk("s3_write", 32'(a1.stopped), 32'd0);
    cyc(p0, idle, 1'b0, 1'b1);
    chk("s3_popfull", 32'(a0.stopped), 32'd1);
    cyc(p0, idle, 1'b0, 1'b0);
    chk("s3_slot", 32'(a0.stopped), 32'd0);
    drain();

    // cache stalls with both requesters waiting
    p0 = mk(1'b0, 20'h04000);
    p1 = mk(1'b0, 20'h05000);
    for (int i = 0; i < 3; i++) cyc(p0, p1, 1'b1, 1'b0);
    cyc(p0, p1, 1'b0, 1'b0);
    chk("s4_resume0", 32'(a0.stopped), 32'd0);
    cyc(idle, p1, 1'b0, 1'b0);
    drain();

    // orphan ready
    cyc(idle, idle, 1'b0, 1'b1);
    chk("s5_noready", 32'({a0.ready, a1.ready}), 32'd0);
    cyc(idle, idle, 1'b0, 1'b0);
    chk("s5_err", 32'(err), 32'd1);
    cyc(idle, idle, 1'b0, 1'b0);

    // reset with reads in flight
    for (int i = 0; i < 3; i++)
      cyc(mk(1'b0, 20'h06000 + 20'(i)), idle, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    r0  = '0;
    r1  = '0;
    c   = '0;
    #1;
    chk("s6_outst", 32'(outst), 32'd0);
    chk("s6_err", 32'(err), 32'd0);
    chk("s6_stop", 32'({a0.stopped, a1.stopped}), 32'd3);
    mcount = 0;
    mprio  = 1'b0;
    merr   = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    cache_q.delete();
    @(negedge clk);
    rst = 1'b0;
    cyc(idle, mk(1'b0, 20'h07777), 1'b0, 1'b0);
    cyc(idle, idle, 1'b0, 1'b1);
    chk("s6_ready1", 32'(a1.ready), 32'd1);
    chk("s6_ready0", 32'(a0.ready), 32'd0);

    // random mix with held requests
    p0 = idle;
    p1 = idle;
    for (int i = 0; i < 600; i++) begin
      if (!p0.valid && $urandom_range(1, 0) == 1)
        p0 = mk($urandom_range(9, 0) < 3, 20'($urandom));
      if (!p1.valid && $urandom_range(1, 0) == 1)
        p1 = mk($urandom_range(9, 0) < 3, 20'($urandom));
      cyc(p0, p1, $urandom_range(3, 0) == 0,
          cache_q.size() > 0 && $urandom_range(2, 0) == 0);
      if (acc0) p0 = idle;
      if (acc1) p1 = idle;
    end
    drain();
    chk("end_exp0_empty", 32'(exp_q0.size()), 32'd0);
    chk("end_exp1_empty", 32'(exp_q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
